chunked_add_sub: RTL and testbench

//  Multi-cycle parametrised adder/subtractor; next generation of the ALU ADD unit.

---
 rtl/chunked_add_sub_pkg.sv | 33 +++
 rtl/chunked_add_sub_if.sv | 26 ++
 rtl/chunked_add_sub_chunk_adder.sv | 17 +
 rtl/chunked_add_sub.sv | 131 +++++++++++++
 tb/tb_chunked_add_sub.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/chunked_add_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor: operation codes,
// controller state encoding and the initial-carry selection.
package chunked_add_sub_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ADC = 2'b10,
        MODE_SBB = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Carry fed into the least significant chunk. Subtraction is done as
    // A + ~B + 1, so the borrow forms use the inverted carry input.
    function automatic logic initialCarry(input logic [1:0] mode, input logic carryIn);
        logic c;
        c = 1'b0;
        case (mode)
            MODE_ADD: c = 1'b0;
            MODE_SUB: c = 1'b1;
            MODE_ADC: c = carryIn;
            MODE_SBB: c = ~carryIn;
            default:  c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/chunked_add_sub_if.sv
// Request/response bundle between a client and the chunked adder/subtractor.
interface chunked_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             carryIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output start, mode, data1, data2, carryIn,
        input  busy, done, result, carry, overflow, zero
    );

    modport slave (
        input  start, mode, data1, data2, carryIn,
        output busy, done, result, carry, overflow, zero
    );
endinterface

// File: rtl/chunked_add_sub_chunk_adder.sv
// Combinational CHUNK-bit ripple slice used once per compute cycle.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    // One-bit-wider add so the carry out falls out of the top bit.
    always_comb begin
        {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
    end

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock from the LSB
// with a registered carry, then publishes RESULT and flags with a DONE pulse.
// WIDTH must be a multiple of CHUNK.
module chunked_add_sub
    import chunked_add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input logic               clk,
    input logic               rst,
    chunked_add_sub_if.slave  bus
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic             aSign_q, aSign_d;
    logic             bSign_q, bSign_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carryOut_q, carryOut_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] chunkSum;
    logic             chunkCout;
    logic [WIDTH-1:0] bAccept;
    logic [WIDTH-1:0] aShifted;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .a_i    (a_q[CHUNK-1:0]),
        .b_i    (b_q[CHUNK-1:0]),
        .cin_i  (carry_q),
        .sum_o  (chunkSum),
        .cout_o (chunkCout)
    );

    // Operand A doubles as the result accumulator: its low chunk is consumed
    // each cycle and the new sum chunk enters at the top, so after N shifts
    // the register holds the finished result. The operand sign bits are kept
    // aside because the overflow rule needs them once A has been overwritten.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        aSign_d    = aSign_q;
        bSign_d    = bSign_q;
        result_d   = result_q;
        carryOut_d = carryOut_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        bAccept  = bus.mode[0] ? ~bus.data2 : bus.data2;
        aShifted = (a_q >> CHUNK) | (WIDTH'(chunkSum) << (WIDTH - CHUNK));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    a_d     = bus.data1;
                    b_d     = bAccept;
                    carry_d = initialCarry(bus.mode, bus.carryIn);
                    aSign_d = bus.data1[WIDTH-1];
                    bSign_d = bAccept[WIDTH-1];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = aShifted;
                b_d     = b_q >> CHUNK;
                carry_d = chunkCout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CHUNK) begin
                    state_d    = ST_DONE;
                    result_d   = aShifted;
                    carryOut_d = chunkCout;
                    overflow_d = (aSign_q == bSign_q) && (aShifted[WIDTH-1] != aSign_q);
                    zero_d     = (aShifted == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and published results; reset abandons any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            aSign_q    <= 1'b0;
            bSign_q    <= 1'b0;
            result_q   <= '0;
            carryOut_q <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            aSign_q    <= aSign_d;
            bSign_q    <= bSign_d;
            result_q   <= result_d;
            carryOut_q <= carryOut_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.result   = result_q;
    assign bus.carry    = carryOut_q;
    assign bus.overflow = overflow_q;
    assign bus.zero     = zero_q;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Self-checking bench for chunked_add_sub: an 8-bit/4-bit instance and a
// 16-bit/4-bit instance, checked against an arithmetic reference model.
module tb_chunked_add_sub;
    import chunked_add_sub_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    chunked_add_sub_if #(.WIDTH(8))  bus8 ();
    chunked_add_sub_if #(.WIDTH(16)) bus16 ();

    chunked_add_sub #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive the request side of the selected instance.
    task automatic applyStimulus(input int w, input logic start, input logic [1:0] mode,
                                 input logic [15:0] a, input logic [15:0] b, input logic cin);
        if (w == 16) begin
            bus16.start = start; bus16.mode = mode; bus16.data1 = a; bus16.data2 = b; bus16.carryIn = cin;
        end else begin
            bus8.start = start; bus8.mode = mode; bus8.data1 = a[7:0]; bus8.data2 = b[7:0]; bus8.carryIn = cin;
        end
    endtask

    task automatic sampleOutputs(input int w, output logic busy, output logic done, output logic [15:0] r,
                                 output logic c, output logic ov, output logic z);
        if (w == 16) begin
            busy = bus16.busy; done = bus16.done; r = bus16.result;
            c = bus16.carry; ov = bus16.overflow; z = bus16.zero;
        end else begin
            busy = bus8.busy; done = bus8.done; r = 16'(bus8.result);
            c = bus8.carry; ov = bus8.overflow; z = bus8.zero;
        end
    endtask

    // Reference: whole-word unsigned sum for result/carry, signed range test for overflow.
    function automatic void refModel(input int w, input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, output logic [15:0] r, output logic c,
                                     output logic ov, output logic z);
        longint mask, half, bOp, c0, full, sa, sb, s;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        bOp  = m[0] ? ((~longint'(b)) & mask) : (longint'(b) & mask);
        if (m == MODE_ADD)      c0 = 0;
        else if (m == MODE_SUB) c0 = 1;
        else if (m == MODE_ADC) c0 = longint'(cin);
        else                    c0 = longint'(!cin);
        full = (longint'(a) & mask) + bOp + c0;
        r    = 16'(full & mask);
        c    = ((full >> w) & 1) != 0;
        sa   = ((longint'(a) & mask) >= half) ? (longint'(a) & mask) - 2 * half : (longint'(a) & mask);
        sb   = (bOp >= half) ? bOp - 2 * half : bOp;
        s    = sa + sb + c0;
        ov   = (s >= half) || (s < -half);
        z    = (full & mask) == 0;
    endfunction

    // One complete operation: accept, latency, result/flags, single-cycle DONE, hold.
    task automatic runOp(input string name, input int w, input logic [1:0] m,
                         input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [15:0] er, r;
        logic ec, eov, ez, busy, done, c, ov, z;
        int lat;
        refModel(w, m, a, b, cin, er, ec, eov, ez);
        @(negedge clk);
        applyStimulus(w, 1'b1, m, a, b, cin);
        @(negedge clk);
        applyStimulus(w, 1'b0, 2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        sampleOutputs(w, busy, done, r, c, ov, z);
        checkOutput({name, ".busy"}, busy, 1);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            sampleOutputs(w, busy, done, r, c, ov, z);
        end
        checkOutput({name, ".latency"}, lat, w / 4);
        checkOutput({name, ".result"}, r, er);
        checkOutput({name, ".carry"}, c, ec);
        checkOutput({name, ".overflow"}, ov, eov);
        checkOutput({name, ".zero"}, z, ez);
        checkOutput({name, ".busyAtDone"}, busy, 0);
        @(negedge clk);
        sampleOutputs(w, busy, done, r, c, ov, z);
        checkOutput({name, ".donePulse"}, done, 0);
        checkOutput({name, ".hold"}, r, er);
    endtask

    initial begin
        logic [15:0] er, r;
        logic ec, eov, ez, busy, done, c, ov, z, sawDone;
        logic [1:0]  sm [6];
        logic [15:0] sa [6];
        logic [15:0] sb [6];
        logic        sc [6];
        int idx;

        rst = 1'b1;
        applyStimulus(8, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
        applyStimulus(16, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        for (int w = 8; w <= 16; w += 8) begin
            sampleOutputs(w, busy, done, r, c, ov, z);
            checkOutput($sformatf("reset%0d.busy", w), busy, 0);
            checkOutput($sformatf("reset%0d.done", w), done, 0);
            checkOutput($sformatf("reset%0d.result", w), r, 0);
            checkOutput($sformatf("reset%0d.flags", w), {c, ov, z}, 0);
        end
        rst = 1'b0;

        $display("[TB] directed operations");
        runOp("add7F01", 8, MODE_ADD, 16'h7F, 16'h01, 1'b0);
        runOp("sub0505", 8, MODE_SUB, 16'h05, 16'h05, 1'b0);
        runOp("sub0001", 8, MODE_SUB, 16'h00, 16'h01, 1'b0);
        runOp("adcFF00", 8, MODE_ADC, 16'hFF, 16'h00, 1'b1);
        runOp("sbb1001", 8, MODE_SBB, 16'h10, 16'h01, 1'b0);
        runOp("sub16",   16, MODE_SUB, 16'h8000, 16'h0001, 1'b0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 24; i++)
            runOp($sformatf("rand8_%0d", i), 8, 2'($urandom), 16'($urandom_range(0, 255)),
                  16'($urandom_range(0, 255)), 1'($urandom));
        for (int i = 0; i < 8; i++)
            runOp($sformatf("rand16_%0d", i), 16, 2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));

        $display("[TB] START held for six cycles");
        for (int i = 0; i < 6; i++) begin
            sm[i] = 2'($urandom); sa[i] = 16'($urandom_range(0, 255));
            sb[i] = 16'($urandom_range(0, 255)); sc[i] = 1'($urandom);
        end
        @(negedge clk);
        applyStimulus(8, 1'b1, sm[0], sa[0], sb[0], sc[0]);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            sampleOutputs(8, busy, done, r, c, ov, z);
            checkOutput($sformatf("stream.done%0d", k), done, (k == 2 || k == 5));
            if (k == 2 || k == 5) begin
                idx = (k == 2) ? 0 : 3;
                refModel(8, sm[idx], sa[idx], sb[idx], sc[idx], er, ec, eov, ez);
                checkOutput($sformatf("stream.result%0d", k), r, er);
                checkOutput($sformatf("stream.flags%0d", k), {c, ov, z}, {ec, eov, ez});
            end
            if (k + 1 < 6) applyStimulus(8, 1'b1, sm[k+1], sa[k+1], sb[k+1], sc[k+1]);
            else           applyStimulus(8, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0);
        end

        $display("[TB] reset during an operation");
        runOp("preReset", 8, MODE_ADD, 16'hF0, 16'h20, 1'b0);
        @(negedge clk);
        applyStimulus(8, 1'b1, MODE_ADD, 16'h11, 16'h22, 1'b0);
        @(negedge clk);
        applyStimulus(8, 1'b0, MODE_ADD, 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        #1;
        sampleOutputs(8, busy, done, r, c, ov, z);
        checkOutput("midReset.busy", busy, 0);
        checkOutput("midReset.result", r, 0);
        checkOutput("midReset.flags", {done, c, ov, z}, 0);
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            sampleOutputs(8, busy, done, r, c, ov, z);
            sawDone = sawDone | done | busy;
        end
        checkOutput("midReset.noDone", sawDone, 0);
        runOp("postReset", 8, MODE_SUB, 16'h40, 16'h41, 1'b0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Guard against a stalled run so the bench always terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
